// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory bus, the redirect request and the decode-side head port.
// The slave modport is the prefetch queue itself; master is whatever drives it.
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    modport slave (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc4
    );

    modport master (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc4
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers returned words in
// program order and flushes on redirect, dropping responses that were already in flight.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] pcf_rd_q, pcf_rd_d;
    logic [AW-1:0] pcf_wr_q, pcf_wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0]   buf_pc_q    [DEPTH];
    logic [31:0]   buf_instr_q [DEPTH];
    logic [31:0]   pcf_q       [DEPTH];

    logic grant;
    logic rsp;
    logic rsp_keep;
    logic pop;
    logic unused_rpc_lo;

    assign unused_rpc_lo = ^bus.redirect_pc[1:0];

    // Slots are reserved at grant, so buffered + outstanding never exceeds DEPTH.
    assign bus.mem_req  = !reset && !bus.redirect &&
                          ((int'(count_q) + int'(outst_q)) < DEPTH);
    assign bus.mem_addr = fetch_pc_q;

    assign grant    = bus.mem_req && bus.mem_gnt;
    assign rsp      = bus.mem_rvalid && (outst_q != '0) && !reset;
    assign rsp_keep = rsp && (discard_q == '0) && !bus.redirect;

    assign bus.out_valid = (count_q != '0) && !reset;
    assign bus.out_pc    = buf_pc_q[rd_ptr_q];
    assign bus.out_pc4   = buf_pc_q[rd_ptr_q] + 32'd4;
    assign bus.out_instr = buf_instr_q[rd_ptr_q];
    assign pop           = bus.out_valid && bus.out_ready && !bus.redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pcf_rd_d   = pcf_rd_q;
        pcf_wr_d   = pcf_wr_q;
        count_d    = count_q;
        outst_d    = outst_q + CW'(grant) - CW'(rsp);
        discard_d  = discard_q;

        if (bus.redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            pcf_rd_d   = '0;
            pcf_wr_d   = '0;
            count_d    = '0;
            discard_d  = outst_q - CW'(rsp);
        end else begin
            if (rsp && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (rsp_keep) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pcf_rd_d = pcf_rd_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcf_wr_d   = pcf_wr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pcf_rd_q   <= '0;
            pcf_wr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pcf_rd_q   <= pcf_rd_d;
            pcf_wr_q   <= pcf_wr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            pcf_q[pcf_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            buf_pc_q[wr_ptr_q]    <= pcf_q[pcf_rd_q];
            buf_instr_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    // A response with nothing outstanding is a bus protocol violation.
    assert property (@(posedge clk) disable iff (reset) bus.mem_rvalid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order memory responder and a queue-based
// reference model checked every cycle, plus literal spot checks per scenario.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [31:0] pc; bit stale; }        fly_t;
    typedef struct { logic [31:0] a;  int due; }          mr_t;

    ent_t        mbuf[$];
    fly_t        mfly[$];
    mr_t         mq[$];
    logic [31:0] popped[$];
    logic [31:0] m_fetch = RESET_PC;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int g_cnt = 0;

    logic        s_reset = 1'b1;
    logic        s_redir = 1'b0;
    logic        s_ready = 1'b0;
    logic        s_gnt   = 1'b0;
    logic        s_hold  = 1'b0;
    logic [31:0] s_rpc   = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance memory and model.
    task automatic step();
        logic er, eo, pop;
        mr_t  r;
        fly_t f;
        @(negedge clk);
        reset           = s_reset;
        bus.redirect    = s_redir;
        bus.redirect_pc = s_rpc;
        bus.out_ready   = s_ready;
        bus.mem_gnt     = s_gnt;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'hDEAD_BEEF ^ 32'(cyc);
        if (!s_reset && !s_hold && mq.size() != 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = instr_of(r.a);
        end
        #1;
        er = !s_reset && !s_redir && ((mbuf.size() + mfly.size()) < DEPTH);
        eo = !s_reset && (mbuf.size() != 0);
        chk("mem_req", 32'(bus.mem_req), 32'(er));
        if (er) chk("mem_addr", bus.mem_addr, m_fetch);
        chk("out_valid", 32'(bus.out_valid), 32'(eo));
        if (eo) begin
            chk("out_pc", bus.out_pc, mbuf[0].pc);
            chk("out_pc4", bus.out_pc4, mbuf[0].pc + 32'd4);
            chk("out_instr", bus.out_instr, mbuf[0].ins);
        end

        if (bus.mem_req && s_gnt) begin
            mq.push_back('{bus.mem_addr, cyc + lat});
            g_cnt++;
        end
        if (bus.out_valid && s_ready && !s_redir) popped.push_back(bus.out_pc);
        if (s_reset) mq.delete();

        if (s_reset) begin
            mbuf.delete();
            mfly.delete();
            m_fetch = RESET_PC;
        end else begin
            pop = (mbuf.size() != 0) && s_ready && !s_redir;
            if (pop) mbuf.delete(0);
            if (bus.mem_rvalid && mfly.size() != 0) begin
                f = mfly.pop_front();
                if (!f.stale && !s_redir) mbuf.push_back('{f.pc, bus.mem_rdata});
            end
            if (s_redir) begin
                mbuf.delete();
                foreach (mfly[i]) mfly[i].stale = 1'b1;
                m_fetch = {s_rpc[31:2], 2'b00};
            end else if (er && s_gnt) begin
                mfly.push_back('{m_fetch, 1'b0});
                m_fetch = m_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        s_reset = 1'b1; s_redir = 1'b0; s_gnt = 1'b0; s_ready = 1'b0; s_hold = 1'b0;
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        step();
        s_reset = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            step();
            if (bus.out_valid) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'h1);
    endtask

    logic [31:0] e2 [4];
    logic [23:0] gp;
    logic [23:0] rp;
    int          npop;

    initial begin
        reset = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // Streaming fetch, one word per cycle
        do_reset();
        lat = 1; s_gnt = 1'b1; s_ready = 1'b1;
        step();
        chk("t1_addr0", bus.mem_addr, 32'h0);
        step();
        chk("t1_valid_early", 32'(bus.out_valid), 32'h0);
        chk("t1_addr1", bus.mem_addr, 32'h4);
        step();
        chk("t1_valid", 32'(bus.out_valid), 32'h1);
        chk("t1_pc", bus.out_pc, 32'h0);
        chk("t1_pc4", bus.out_pc4, 32'h4);
        chk("t1_instr", bus.out_instr, 32'hA5A5_5A5A);
        steps(6);
        chk("t1_pc_run", bus.out_pc, 32'h18);

        // Consumer stall fills the queue, then drains in order
        do_reset();
        s_gnt = 1'b1; s_ready = 1'b0; g_cnt = 0;
        steps(10);
        chk("t2_grants", 32'(g_cnt), 32'd4);
        chk("t2_req_low", 32'(bus.mem_req), 32'h0);
        chk("t2_pc_held", bus.out_pc, 32'h0);
        popped.delete();
        s_ready = 1'b1;
        step();
        chk("t2_req_full", 32'(bus.mem_req), 32'h0);
        step();
        chk("t2_resume_req", 32'(bus.mem_req), 32'h1);
        chk("t2_resume_addr", bus.mem_addr, 32'h10);
        steps(2);
        e2 = '{32'h0, 32'h4, 32'h8, 32'hC};
        npop = popped.size();
        chk("t2_npop", 32'(npop), 32'd4);
        for (int i = 0; i < 4; i++) if (i < npop) chk("t2_pop_pc", popped[i], e2[i]);

        // Redirect with two fetches in flight
        do_reset();
        s_hold = 1'b1; s_gnt = 1'b1; s_ready = 1'b1; lat = 1;
        steps(2);
        s_gnt = 1'b0;
        s_redir = 1'b1; s_rpc = 32'h0000_0103; s_hold = 1'b0;
        step();
        chk("t3_req_redir", 32'(bus.mem_req), 32'h0);
        s_redir = 1'b0; s_gnt = 1'b1;
        step();
        chk("t3_new_addr", bus.mem_addr, 32'h100);
        wait_valid("t3_wait");
        chk("t3_pc", bus.out_pc, 32'h100);
        chk("t3_instr", bus.out_instr, 32'hA5A5_5B5A);

        // Redirect coinciding with a response and a ready consumer
        do_reset();
        s_gnt = 1'b1; s_ready = 1'b1; lat = 1;
        steps(3);
        npop = popped.size();
        s_redir = 1'b1; s_rpc = 32'h0000_0200;
        step();
        chk("t4_no_pop", 32'(popped.size()), 32'(npop));
        s_redir = 1'b0;
        step();
        chk("t4_valid_low", 32'(bus.out_valid), 32'h0);
        wait_valid("t4_wait");
        chk("t4_pc", bus.out_pc, 32'h200);

        // Address wrap at the top of memory
        s_redir = 1'b1; s_rpc = 32'hFFFF_FFFC;
        step();
        s_redir = 1'b0;
        wait_valid("t5_wait");
        chk("t5_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("t5_pc4", bus.out_pc4, 32'h0);
        chk("t5_instr", bus.out_instr, 32'h5A5A_A5A6);
        step();
        chk("t5_valid2", 32'(bus.out_valid), 32'h1);
        chk("t5_pc2", bus.out_pc, 32'h0);

        // Reset with two buffered and two in flight
        do_reset();
        s_gnt = 1'b1; s_ready = 1'b0; lat = 1;
        steps(3);
        s_hold = 1'b1;
        steps(2);
        chk("t6_full_req", 32'(bus.mem_req), 32'h0);
        chk("t6_full_valid", 32'(bus.out_valid), 32'h1);
        s_reset = 1'b1;
        step();
        chk("t6_rst_req", 32'(bus.mem_req), 32'h0);
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        step();
        chk("t6_rst_valid2", 32'(bus.out_valid), 32'h0);
        s_reset = 1'b0; s_hold = 1'b0; s_ready = 1'b1;
        step();
        chk("t6_restart_req", 32'(bus.mem_req), 32'h1);
        chk("t6_restart_addr", bus.mem_addr, RESET_PC);
        wait_valid("t6_wait");
        chk("t6_pc", bus.out_pc, RESET_PC);

        // Irregular grant/ready pattern with slower memory and a mid-run redirect
        lat = 2;
        gp = 24'b1011_0111_1101_1110_0111_1011;
        rp = 24'b1100_1110_0011_1101_1001_0111;
        for (int i = 0; i < 24; i++) begin
            s_gnt   = gp[i];
            s_ready = rp[i];
            s_redir = (i == 13);
            s_rpc   = 32'h0000_4446;
            step();
        end
        s_redir = 1'b0; s_gnt = 1'b0; s_ready = 1'b1;
        steps(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
